// File: rtl/cpu_fde_pipeline.sv
// Moxie front end: fetches 16-bit big-endian opcodes (plus the ldi.l immediate), decodes an ALU subset
// and registers the execute result. Decode is 1 edge and execute 2 edges after fetch; stall freezes every stage.
module cpu_fde_pipeline #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  output logic [31:0] imem_address_o,
  input  logic [31:0] imem_data_i,
  output logic        register_A_read_enable_o,
  output logic        register_B_read_enable_o,
  output logic [3:0]  riA_o,
  output logic [3:0]  riB_o,
  input  logic [31:0] regA_i,
  input  logic [31:0] regB_i,
  output logic        register_write_enable_o,
  output logic [3:0]  register_write_index_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {S_REQ_OP, S_RX_OP, S_REQ_ARG, S_RX_ARG} fetch_state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NEG
  } op_t;

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [15:0]  r_imm_hi;
  logic         r_fvld;
  logic [15:0]  r_fop;
  logic [31:0]  r_foperand;

  op_t          r_dop;
  logic         r_rd_a;
  logic         r_rd_b;
  logic [3:0]   r_ri_a;
  logic [3:0]   r_ri_b;
  logic [31:0]  r_doperand;

  logic         r_we;
  logic [3:0]   r_widx;
  logic [31:0]  r_result;

  logic [31:0]  w_word_addr;
  logic [15:0]  w_opcode;
  op_t          w_op;
  logic         w_rd_a;
  logic         w_rd_b;
  logic [31:0]  w_result;

  // The address stays put through each RX state so the returned word is still valid there.
  assign w_word_addr    = {r_pc[31:2], 2'b00};
  assign imem_address_o = (r_state == S_REQ_ARG || r_state == S_RX_ARG) ? w_word_addr + 32'd4
                                                                        : w_word_addr;
  assign w_opcode       = r_pc[1] ? imem_data_i[15:0] : imem_data_i[31:16];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_REQ_OP;
      r_pc       <= RESET_PC;
      r_imm_hi   <= 16'd0;
      r_fvld     <= 1'b0;
      r_fop      <= 16'd0;
      r_foperand <= 32'd0;
    end else if (!stall_i) begin
      r_fvld <= 1'b0;
      case (r_state)
        S_REQ_OP: r_state <= S_RX_OP;
        S_RX_OP: begin
          r_fop <= w_opcode;
          if (w_opcode[15:8] == 8'h01) begin
            r_imm_hi <= imem_data_i[15:0];
            r_state  <= S_REQ_ARG;
          end else begin
            r_fvld  <= 1'b1;
            r_pc    <= r_pc + 32'd2;
            r_state <= S_REQ_OP;
          end
        end
        S_REQ_ARG: r_state <= S_RX_ARG;
        S_RX_ARG: begin
          r_foperand <= r_pc[1] ? imem_data_i : {r_imm_hi, imem_data_i[31:16]};
          r_fvld     <= 1'b1;
          r_pc       <= r_pc + 32'd6;
          r_state    <= S_REQ_OP;
        end
        default: r_state <= S_REQ_OP;
      endcase
    end
  end

  always_comb begin
    w_op   = OP_NOP;
    w_rd_a = 1'b0;
    w_rd_b = 1'b0;
    if (r_fvld) begin
      case (r_fop[15:8])
        8'h01: w_op = OP_LDI;
        8'h02: begin w_op = OP_MOV; w_rd_b = 1'b1; end
        8'h2c: begin w_op = OP_NOT; w_rd_b = 1'b1; end
        8'h2a: begin w_op = OP_NEG; w_rd_b = 1'b1; end
        8'h05: begin w_op = OP_ADD; w_rd_a = 1'b1; w_rd_b = 1'b1; end
        8'h29: begin w_op = OP_SUB; w_rd_a = 1'b1; w_rd_b = 1'b1; end
        8'h26: begin w_op = OP_AND; w_rd_a = 1'b1; w_rd_b = 1'b1; end
        8'h2b: begin w_op = OP_OR;  w_rd_a = 1'b1; w_rd_b = 1'b1; end
        8'h2e: begin w_op = OP_XOR; w_rd_a = 1'b1; w_rd_b = 1'b1; end
        default: w_op = OP_NOP;
      endcase
    end
  end

  // Indices and operand only move on real instructions; bubbles leave them parked.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_dop      <= OP_NOP;
      r_rd_a     <= 1'b0;
      r_rd_b     <= 1'b0;
      r_ri_a     <= 4'd0;
      r_ri_b     <= 4'd0;
      r_doperand <= 32'd0;
    end else if (!stall_i) begin
      r_dop  <= w_op;
      r_rd_a <= w_rd_a;
      r_rd_b <= w_rd_b;
      if (w_op != OP_NOP) begin
        r_ri_a     <= r_fop[7:4];
        r_ri_b     <= r_fop[3:0];
        r_doperand <= r_foperand;
      end
    end
  end

  always_comb begin
    w_result = 32'd0;
    case (r_dop)
      OP_LDI:  w_result = r_doperand;
      OP_MOV:  w_result = regB_i;
      OP_ADD:  w_result = regA_i + regB_i;
      OP_SUB:  w_result = regA_i - regB_i;
      OP_AND:  w_result = regA_i & regB_i;
      OP_OR:   w_result = regA_i | regB_i;
      OP_XOR:  w_result = regA_i ^ regB_i;
      OP_NOT:  w_result = ~regB_i;
      OP_NEG:  w_result = 32'd0 - regB_i;
      default: w_result = 32'd0;
    endcase
  end

  // A stalled edge drops the write request so the held result is not written twice.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we     <= 1'b0;
      r_widx   <= 4'd0;
      r_result <= 32'd0;
    end else if (stall_i) begin
      r_we <= 1'b0;
    end else begin
      r_we <= (r_dop != OP_NOP);
      if (r_dop != OP_NOP) begin
        r_widx   <= r_ri_a;
        r_result <= w_result;
      end
    end
  end

  assign register_A_read_enable_o = r_rd_a;
  assign register_B_read_enable_o = r_rd_b;
  assign riA_o                    = r_ri_a;
  assign riB_o                    = r_ri_b;
  assign register_write_enable_o  = r_we;
  assign register_write_index_o   = r_widx;
  assign result_o                 = r_result;

endmodule

// File: tb/tb_cpu_fde_pipeline.sv
// Bench for cpu_fde_pipeline: instruction-level model over a byte-addressed memory image,
// per-cycle compare against queued reads/writes, plus directed literal checks.
`timescale 1ns/1ps
module tb_cpu_fde_pipeline;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic [31:0] imem_address_o;
  logic [31:0] imem_data_i;
  logic        register_A_read_enable_o;
  logic        register_B_read_enable_o;
  logic [3:0]  riA_o;
  logic [3:0]  riB_o;
  logic [31:0] regA_i;
  logic [31:0] regB_i;
  logic        register_write_enable_o;
  logic [3:0]  register_write_index_o;
  logic [31:0] result_o;

  cpu_fde_pipeline #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i                    (clk_i),
    .rst_i                    (rst_i),
    .stall_i                  (stall_i),
    .imem_address_o           (imem_address_o),
    .imem_data_i              (imem_data_i),
    .register_A_read_enable_o (register_A_read_enable_o),
    .register_B_read_enable_o (register_B_read_enable_o),
    .riA_o                    (riA_o),
    .riB_o                    (riB_o),
    .regA_i                   (regA_i),
    .regB_i                   (regB_i),
    .register_write_enable_o  (register_write_enable_o),
    .register_write_index_o   (register_write_index_o),
    .result_o                 (result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [3:0] idx; logic [31:0] res; } wr_t;
  typedef struct packed { logic rda; logic rdb; logic [3:0] ia; logic [3:0] ib; } rd_t;

  logic [31:0] mem  [0:63];
  logic [31:0] regs [0:15];
  wr_t         wq[$];
  rd_t         rq[$];
  int          checks = 0;
  int          errors = 0;
  logic        stall_seen = 1'b0;
  logic [35:0] prev_ex = '0;
  logic [9:0]  prev_dec = '0;
  wr_t         e_w;
  rd_t         e_r;
  logic [31:0] t1_addr [0:6] = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd4, 32'd4, 32'd8};

  always @(posedge clk_i) imem_data_i <= mem[imem_address_o[7:2]];
  assign regA_i = regs[riA_o];
  assign regB_i = regs[riB_o];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[7:2]];
    return 8'(w >> (8 * (3 - int'(a[1:0]))));
  endfunction

  task automatic push_w(input logic [3:0] i, input logic [31:0] v);
    wr_t t;
    t.idx = i;
    t.res = v;
    wq.push_back(t);
  endtask

  task automatic push_r(input logic ra, input logic rb, input logic [3:0] ia, input logic [3:0] ib);
    rd_t t;
    t.rda = ra;
    t.rdb = rb;
    t.ia  = ia;
    t.ib  = ib;
    rq.push_back(t);
  endtask

  // Walk the program as a byte stream from address 0 and queue the reads/writes it must cause.
  task automatic build_model(input logic [31:0] stop_pc);
    logic [31:0] pc;
    logic [15:0] op;
    logic [3:0]  a;
    logic [3:0]  b;
    pc = 32'd0;
    while (pc < stop_pc) begin
      op = {mbyte(pc), mbyte(pc + 32'd1)};
      pc = pc + 32'd2;
      a  = op[7:4];
      b  = op[3:0];
      case (op[15:8])
        8'h01: begin
          push_w(a, {mbyte(pc), mbyte(pc + 32'd1), mbyte(pc + 32'd2), mbyte(pc + 32'd3)});
          pc = pc + 32'd4;
        end
        8'h02: begin push_r(1'b0, 1'b1, a, b); push_w(a, regs[b]); end
        8'h2c: begin push_r(1'b0, 1'b1, a, b); push_w(a, ~regs[b]); end
        8'h2a: begin push_r(1'b0, 1'b1, a, b); push_w(a, 32'd0 - regs[b]); end
        8'h05: begin push_r(1'b1, 1'b1, a, b); push_w(a, regs[a] + regs[b]); end
        8'h29: begin push_r(1'b1, 1'b1, a, b); push_w(a, regs[a] - regs[b]); end
        8'h26: begin push_r(1'b1, 1'b1, a, b); push_w(a, regs[a] & regs[b]); end
        8'h2b: begin push_r(1'b1, 1'b1, a, b); push_w(a, regs[a] | regs[b]); end
        8'h2e: begin push_r(1'b1, 1'b1, a, b); push_w(a, regs[a] ^ regs[b]); end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk_i) stall_seen <= stall_i;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      check("reset_ctrl", {register_A_read_enable_o, register_B_read_enable_o, riA_o, riB_o,
                           register_write_enable_o, register_write_index_o}, 64'd0);
      check("reset_data", {result_o, imem_address_o}, 64'd0);
    end else if (stall_seen) begin
      check("stall_we", register_write_enable_o, 64'd0);
      check("stall_exec_hold", {register_write_index_o, result_o}, prev_ex);
      check("stall_dec_hold", {register_A_read_enable_o, register_B_read_enable_o, riA_o, riB_o}, prev_dec);
    end else begin
      if (register_A_read_enable_o || register_B_read_enable_o) begin
        if (rq.size() == 0) begin
          check("unexpected_read", {register_A_read_enable_o, register_B_read_enable_o}, 64'd0);
        end else begin
          e_r = rq.pop_front();
          check("read_enables", {register_A_read_enable_o, register_B_read_enable_o}, {e_r.rda, e_r.rdb});
          if (e_r.rda) check("riA", riA_o, e_r.ia);
          if (e_r.rdb) check("riB", riB_o, e_r.ib);
        end
      end
      if (register_write_enable_o) begin
        if (wq.size() == 0) begin
          check("unexpected_write", register_write_enable_o, 64'd0);
        end else begin
          e_w = wq.pop_front();
          check("write_index", register_write_index_o, e_w.idx);
          check("write_result", result_o, e_w.res);
        end
      end
    end
    prev_ex  <= {register_write_index_o, result_o};
    prev_dec <= {register_A_read_enable_o, register_B_read_enable_o, riA_o, riB_o};
  end

  task automatic hold_reset();
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    stall_i = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0F00_0F00;
  endtask

  task automatic release_reset(input logic [31:0] stop_pc);
    wq.delete();
    rq.delete();
    build_model(stop_pc);
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b1;
  endtask

  task automatic end_test(input string name);
    check({name, "_writes_left"}, 64'(wq.size()), 64'd0);
    check({name, "_reads_left"}, 64'(rq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int hits;
    rst_i   = 1'b0;
    stall_i = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0F00_0F00;
    for (int i = 0; i < 16; i++) regs[i] = 32'h100 + 32'(i);
    regs[0] = 32'd1; regs[1] = 32'd5; regs[2] = 32'd7; regs[3] = 32'd0; regs[4] = 32'd1;

    // ldi.l $1, 0x2A then nop at PC 6
    hold_reset();
    mem[0] = 32'h0110_0000;
    mem[1] = 32'h002A_0F00;
    release_reset(32'd8);
    check("t1_addr_0", imem_address_o, t1_addr[0]);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk_i);
      #1;
      check($sformatf("t1_addr_%0d", k), imem_address_o, t1_addr[k]);
      if (k == 5) check("t1_we_before", register_write_enable_o, 64'd0);
    end
    check("t1_we", register_write_enable_o, 64'd1);
    check("t1_idx", register_write_index_o, 64'd1);
    check("t1_result", result_o, 64'h2A);
    repeat (10) @(posedge clk_i);
    end_test("t1");

    // reset while the ldi.l is in RX_ARG, after an add has already executed
    hold_reset();
    mem[0] = 32'h0512_0130;
    mem[1] = 32'h1234_5678;
    release_reset(32'd8);
    repeat (5) @(posedge clk_i);
    #1;
    check("t2_result_before_abort", result_o, 64'd12);
    #1 rst_i = 1'b0;
    #1;
    check("t2_abort_we", register_write_enable_o, 64'd0);
    check("t2_abort_result", result_o, 64'd0);
    check("t2_abort_idx", register_write_index_o, 64'd0);
    check("t2_abort_addr", imem_address_o, 64'd0);
    release_reset(32'd8);
    check("t2_model_ldi", wq[1], {4'd3, 32'h1234_5678});
    repeat (16) @(posedge clk_i);
    end_test("t2");

    // register ops
    hold_reset();
    mem[0] = 32'h0512_2934;
    mem[1] = 32'h2A50_0212;
    mem[2] = 32'h2612_2B12;
    mem[3] = 32'h2E12_2C30;
    release_reset(32'd16);
    check("t3_model_add", wq[0], {4'd1, 32'd12});
    check("t3_model_sub", wq[1], {4'd3, 32'hFFFF_FFFF});
    check("t3_model_neg", wq[2], {4'd5, 32'hFFFF_FFFF});
    check("t3_model_neg_reads", rq[2], {1'b0, 1'b1, 4'd5, 4'd0});
    check("t3_model_not", wq[7], {4'd3, 32'hFFFF_FFFE});
    repeat (24) @(posedge clk_i);
    end_test("t3");

    // unaligned ldi.l at PC 2
    hold_reset();
    mem[0] = 32'h0F00_0170;
    mem[1] = 32'hDEAD_BEEF;
    mem[2] = 32'h0532_0F00;
    release_reset(32'd12);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 5) check("t4_arg_addr", imem_address_o, 64'd4);
      if (k == 6) check("t4_next_fetch_addr", imem_address_o, 64'd8);
      if (k == 7) check("t4_we_before", register_write_enable_o, 64'd0);
    end
    check("t4_we", register_write_enable_o, 64'd1);
    check("t4_idx", register_write_index_o, 64'd7);
    check("t4_result", result_o, 64'hDEAD_BEEF);
    repeat (10) @(posedge clk_i);
    end_test("t4");

    // stalls during a stream of adds
    hold_reset();
    mem[0] = 32'h0512_0534;
    mem[1] = 32'h0501_0520;
    mem[2] = 32'h0512_0534;
    mem[3] = 32'h0501_0520;
    release_reset(32'd16);
    repeat (4) @(posedge clk_i);
    #2 stall_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #2 stall_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 stall_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #2 stall_i = 1'b0;
    repeat (24) @(posedge clk_i);
    end_test("t5");

    // undefined opcodes
    hold_reset();
    mem[0] = 32'h0000_FF12;
    release_reset(32'd4);
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk_i);
      #1;
      if (register_A_read_enable_o || register_B_read_enable_o || register_write_enable_o) hits++;
    end
    check("t6_no_activity", 64'(hits), 64'd0);
    end_test("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
